vscale_pc_redirect_ctrl: RTL and testbench
==========================================

# vscale_pc_redirect_ctrl

Sequencing controller for the pre-IF PC mux. It arbitrates same-cycle redirect requests from the DX stage and the trap/CSR logic, and drives `PC_src_sel`. It holds an accepted redirect stable across instruction-memory stalls and converts a misaligned-fetch report from the mux into a handler redirect. It also generates the IF/DX kill signals and keeps a redirect performance counter. It sits in the control unit, between the DX decode/branch logic, the CSR file and the PC mux.

## Interface
- `CNT_WIDTH`, default 32: width of the redirect counter.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `stall_IF` in 1: imem not ready. PC_IF and DX hold this cycle.
- `trap_req` in 1: exception or interrupt to be taken.
- `eret_req` in 1: return from trap.
- `jalr_DX` in 1: JALR in DX.
- `jal_DX` in 1: JAL in DX.
- `branch_taken_DX` in 1: resolved taken branch in DX.
- `misaligned_fetch` in 1: from the PC mux, the candidate target has nonzero `[1:0]`.
- `PC_src_sel` out `PC_SRC_SEL_WIDTH`: source select to the PC mux.
- `kill_IF` out 1: squash the instruction entering DX.
- `kill_DX` out 1: squash the instruction in DX.
- `misaligned_exc` out 1: one-cycle exception report to the CSR file.
- `redirect_pending` out 1: a redirect is latched and waiting for the stall to clear.
- `redirect_count` out `CNT_WIDTH`: accepted non-sequential redirects, wrapping.

## Operation
- **Priority** (highest first): `trap_req` → HANDLER, `eret_req` → EPC, `jalr_DX` → JALR_TARGET, `jal_DX` → JAL_TARGET, `branch_taken_DX` → BRANCH_TARGET. With no request, `stall_IF=1` → REPLAY, otherwise PLUS_FOUR.
- **States:** RUN, HOLD, MISALIGN.
- **RUN:**
  - `PC_src_sel` is combinational from the winning request.
  - Winner present and `stall_IF=0`: redirect is accepted. Assert `kill_IF`. Also assert `kill_DX` when the winner is trap or eret. Increment `redirect_count`.
  - Winner present and `stall_IF=1`: latch the winning source into `held_sel` and go to HOLD.
  - A misaligned jump or branch does not use this path; see the misaligned rule below.
- **HOLD:**
  - `PC_src_sel=held_sel` and `redirect_pending=1`. No kills.
  - A new `trap_req` overrides: `held_sel` becomes HANDLER. Other requests are ignored because DX is frozen.
  - When `stall_IF` falls, the redirect is accepted with the same kill and count rules as RUN, then return to RUN.
- **Misaligned:** `misaligned_fetch=1` on an accepted JAL/JALR/BRANCH redirect is handled as follows.
  - The mux already outputs PC_IF, so the cycle is not counted as a redirect.
  - Assert `kill_IF` and go to MISALIGN.
  - In MISALIGN, pulse `misaligned_exc`, drive `PC_src_sel=HANDLER`, assert `kill_IF` and `kill_DX`, and count one redirect.
  - If `stall_IF=1` in MISALIGN, the exception pulse is still issued once, then HOLD with `held_sel=HANDLER`.
- `misaligned_fetch` is ignored for HANDLER, EPC, REPLAY and PLUS_FOUR selections.
- **Counter:** increments by 1 per accepted redirect and wraps at 2^`CNT_WIDTH`−1 → 0.

## Timing
- Request to `PC_src_sel` in RUN: zero cycles, combinational.
- State, `held_sel` and `redirect_count` update on `clk` rising edge.
- Misaligned detection to HANDLER select: 1 cycle.
- **Reset:** state RUN, `held_sel` PLUS_FOUR, `redirect_count` 0.
  - While `reset=1`, the outputs are `PC_src_sel`=PLUS_FOUR, `kill_IF`=1, `kill_DX`=1, `misaligned_exc`=0, `redirect_pending`=0.
  - Reset asserted mid-HOLD or mid-MISALIGN discards the pending redirect, with no exception pulse.
- `trap_req` and `eret_req` in the same cycle: the trap wins and the eret is dropped.
- `trap_req` while in MISALIGN: a single HANDLER redirect; `misaligned_exc` still pulses.

## Structure
- Add to `vscale_ctrl_constants.vh`:
  - the state encoding (`PRC_STATE_WIDTH`=2, `PRC_RUN`, `PRC_HOLD`, `PRC_MISALIGN`);
  - the existing `PC_*` selector defines, already there.
- No sub-module. The priority encoder is a local function, the counter is inline.

## Test plan
- **Simple branch:** `branch_taken_DX=1`, `stall_IF=0` → same cycle `PC_src_sel`=BRANCH_TARGET, `kill_IF`=1, `kill_DX`=0, count 0→1.
- **JAL under stall:** `jal_DX=1` with `stall_IF=1` for 3 cycles → `redirect_pending`=1 for 3 cycles, `PC_src_sel`=JAL_TARGET throughout. Count increments once, on the cycle `stall_IF` falls.
- **Priority:** `trap_req`, `eret_req` and `jalr_DX` all 1 → HANDLER, `kill_IF`=`kill_DX`=1, count +1.
- **Trap override in HOLD:** `jalr_DX` while stalled, then `trap_req` in cycle 2 → `PC_src_sel` changes to HANDLER. On stall release, a single redirect with `kill_DX`=1.
- **Misaligned JAL:** `jal_DX=1` with `misaligned_fetch=1` → next cycle `misaligned_exc` pulse exactly 1 cycle and `PC_src_sel`=HANDLER. Count +1 total.
- **Reset and wrap:**
  - Reset in HOLD → next cycle RUN, `redirect_pending`=0, count 0.
  - With `CNT_WIDTH`=4, 16 redirects → count returns to 0.

Source files
------------

// File: rtl/vscale_pc_redirect_ctrl_pkg.sv
// rtl/vscale_pc_redirect_ctrl_pkg.sv - PC mux selector encodings, controller state encoding and helpers
//
// Shared definitions for the pre-IF PC redirect controller:
//   PC_SRC_SEL_WIDTH / PC_* : source select values driven to the PC mux
//   PRC_STATE_WIDTH / PRC_* : redirect controller state encoding
//   redirect_req_t          : result of the redirect priority encoder
//   is_jump_target()        : selections whose target may be misaligned
package vscale_pc_redirect_ctrl_pkg;

    localparam int PC_SRC_SEL_WIDTH = 3;

    typedef logic [PC_SRC_SEL_WIDTH-1:0] pc_src_sel_t;

    localparam pc_src_sel_t PC_JAL_TARGET    = 3'd0;
    localparam pc_src_sel_t PC_BRANCH_TARGET = 3'd1;
    localparam pc_src_sel_t PC_REPLAY        = 3'd2;
    localparam pc_src_sel_t PC_HANDLER       = 3'd3;
    localparam pc_src_sel_t PC_EPC           = 3'd4;
    localparam pc_src_sel_t PC_PLUS_FOUR     = 3'd5;
    localparam pc_src_sel_t PC_JALR_TARGET   = 3'd6;

    localparam int PRC_STATE_WIDTH = 2;

    typedef enum logic [PRC_STATE_WIDTH-1:0] {
        PRC_RUN      = 2'd0,
        PRC_HOLD     = 2'd1,
        PRC_MISALIGN = 2'd2
    } prc_state_e;

    typedef struct packed {
        logic        valid;
        pc_src_sel_t sel;
    } redirect_req_t;

    // Only computed jump/branch targets can come out of the mux misaligned;
    // handler, EPC, replay and sequential PCs are aligned by construction.
    function automatic logic is_jump_target(input pc_src_sel_t sel);
        return (sel == PC_JAL_TARGET) || (sel == PC_JALR_TARGET) ||
               (sel == PC_BRANCH_TARGET);
    endfunction

endpackage

// File: rtl/vscale_pc_redirect_ctrl.sv
// rtl/vscale_pc_redirect_ctrl.sv - pre-IF PC mux sequencing, redirect hold, misaligned-fetch trap and kills
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall_IF            : imem not ready, PC_IF and DX hold
//   trap_req, eret_req  : trap entry / trap return requests
//   jalr_DX, jal_DX     : jumps resolved in DX
//   branch_taken_DX     : taken branch resolved in DX
//   misaligned_fetch    : PC mux candidate target has nonzero [1:0]
//   PC_src_sel          : source select to the PC mux
//   kill_IF, kill_DX    : squash the instruction entering / in DX
//   misaligned_exc      : one-cycle misaligned-fetch exception to the CSR file
//   redirect_pending    : a redirect is held waiting for the stall to clear
//   redirect_count      : wrapping count of accepted non-sequential redirects
module vscale_pc_redirect_ctrl
    import vscale_pc_redirect_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall_IF,
    input  logic                        trap_req,
    input  logic                        eret_req,
    input  logic                        jalr_DX,
    input  logic                        jal_DX,
    input  logic                        branch_taken_DX,
    input  logic                        misaligned_fetch,
    output logic [PC_SRC_SEL_WIDTH-1:0] PC_src_sel,
    output logic                        kill_IF,
    output logic                        kill_DX,
    output logic                        misaligned_exc,
    output logic                        redirect_pending,
    output logic [CNT_WIDTH-1:0]        redirect_count
);

    prc_state_e           state_q, state_d;
    pc_src_sel_t          held_sel_q, held_sel_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    redirect_req_t req;
    logic          eff_valid;
    pc_src_sel_t   eff_sel;

    function automatic redirect_req_t prio_encode(
        input logic trap,
        input logic eret,
        input logic jalr,
        input logic jal,
        input logic branch
    );
        redirect_req_t r;
        r.valid = 1'b1;
        if (trap)        r.sel = PC_HANDLER;
        else if (eret)   r.sel = PC_EPC;
        else if (jalr)   r.sel = PC_JALR_TARGET;
        else if (jal)    r.sel = PC_JAL_TARGET;
        else if (branch) r.sel = PC_BRANCH_TARGET;
        else begin
            r.valid = 1'b0;
            r.sel   = PC_PLUS_FOUR;
        end
        return r;
    endfunction

    always_comb begin
        req = prio_encode(trap_req, eret_req, jalr_DX, jal_DX, branch_taken_DX);

        // DX is frozen while holding, so only a trap can displace the held target.
        if (state_q == PRC_HOLD) begin
            eff_valid = 1'b1;
            eff_sel   = trap_req ? PC_HANDLER : held_sel_q;
        end else begin
            eff_valid = req.valid;
            eff_sel   = req.sel;
        end

        state_d          = PRC_RUN;
        held_sel_d       = held_sel_q;
        count_d          = count_q;
        PC_src_sel       = PC_PLUS_FOUR;
        kill_IF          = 1'b0;
        kill_DX          = 1'b0;
        misaligned_exc   = 1'b0;
        redirect_pending = 1'b0;

        if (state_q == PRC_MISALIGN) begin
            // The exception is reported exactly once here; a stall only
            // defers the handler redirect itself, which is counted on release.
            PC_src_sel     = PC_HANDLER;
            kill_IF        = 1'b1;
            kill_DX        = 1'b1;
            misaligned_exc = 1'b1;
            if (stall_IF) begin
                state_d    = PRC_HOLD;
                held_sel_d = PC_HANDLER;
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else begin
            redirect_pending = (state_q == PRC_HOLD);
            if (!eff_valid) begin
                PC_src_sel = stall_IF ? PC_REPLAY : PC_PLUS_FOUR;
            end else begin
                PC_src_sel = eff_sel;
                if (stall_IF) begin
                    state_d    = PRC_HOLD;
                    held_sel_d = eff_sel;
                end else if (misaligned_fetch && is_jump_target(eff_sel)) begin
                    // Mux falls back to PC_IF this cycle; the handler redirect
                    // is issued (and counted) from MISALIGN.
                    kill_IF = 1'b1;
                    state_d = PRC_MISALIGN;
                end else begin
                    kill_IF = 1'b1;
                    kill_DX = (eff_sel == PC_HANDLER) || (eff_sel == PC_EPC);
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end
        end

        if (reset) begin
            PC_src_sel       = PC_PLUS_FOUR;
            kill_IF          = 1'b1;
            kill_DX          = 1'b1;
            misaligned_exc   = 1'b0;
            redirect_pending = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PRC_RUN;
            held_sel_q <= PC_PLUS_FOUR;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            held_sel_q <= held_sel_d;
            count_q    <= count_d;
        end
    end

    assign redirect_count = count_q;

endmodule

// File: tb/tb_vscale_pc_redirect_ctrl.sv
// tb/tb_vscale_pc_redirect_ctrl.sv - self-checking bench for vscale_pc_redirect_ctrl
module tb_vscale_pc_redirect_ctrl;
    import vscale_pc_redirect_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall_IF = 1'b0;
    logic          trap_req = 1'b0;
    logic          eret_req = 1'b0;
    logic          jalr_DX = 1'b0;
    logic          jal_DX = 1'b0;
    logic          branch_taken_DX = 1'b0;
    logic          misaligned_fetch = 1'b0;
    logic [2:0]    PC_src_sel;
    logic          kill_IF;
    logic          kill_DX;
    logic          misaligned_exc;
    logic          redirect_pending;
    logic [CW-1:0] redirect_count;

    always #5 clk = ~clk;

    vscale_pc_redirect_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_IF         (stall_IF),
        .trap_req         (trap_req),
        .eret_req         (eret_req),
        .jalr_DX          (jalr_DX),
        .jal_DX           (jal_DX),
        .branch_taken_DX  (branch_taken_DX),
        .misaligned_fetch (misaligned_fetch),
        .PC_src_sel       (PC_src_sel),
        .kill_IF          (kill_IF),
        .kill_DX          (kill_DX),
        .misaligned_exc   (misaligned_exc),
        .redirect_pending (redirect_pending),
        .redirect_count   (redirect_count)
    );

    int total = 0;
    int bad = 0;

    // Reference model: a pending redirect target (or none) plus an
    // "exception owed next cycle" flag and an integer redirect tally.
    bit m_wait = 1'b0;
    bit m_exc  = 1'b0;
    int m_src  = int'(PC_PLUS_FOUR);
    int m_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int win, src, e_sel, ns, nc;
        bit e_ki, e_kd, e_exc, e_pend, nw, ne, is_jump;
        nw = m_wait; ne = 1'b0; ns = m_src; nc = m_cnt;
        e_ki = 0; e_kd = 0; e_exc = 0; e_pend = 0;
        if (trap_req)             win = int'(PC_HANDLER);
        else if (eret_req)        win = int'(PC_EPC);
        else if (jalr_DX)         win = int'(PC_JALR_TARGET);
        else if (jal_DX)          win = int'(PC_JAL_TARGET);
        else if (branch_taken_DX) win = int'(PC_BRANCH_TARGET);
        else                      win = -1;

        if (reset) begin
            e_sel = int'(PC_PLUS_FOUR); e_ki = 1; e_kd = 1;
            nw = 0; ne = 0; nc = 0; ns = int'(PC_PLUS_FOUR);
        end else if (m_exc) begin
            e_sel = int'(PC_HANDLER); e_ki = 1; e_kd = 1; e_exc = 1;
            if (stall_IF) begin nw = 1; ns = int'(PC_HANDLER); end
            else begin nw = 0; nc = m_cnt + 1; end
        end else begin
            src = m_wait ? (trap_req ? int'(PC_HANDLER) : m_src) : win;
            e_pend = m_wait;
            if (src < 0) begin
                e_sel = stall_IF ? int'(PC_REPLAY) : int'(PC_PLUS_FOUR);
                nw = 0;
            end else begin
                e_sel = src;
                is_jump = (src == int'(PC_JAL_TARGET)) || (src == int'(PC_JALR_TARGET)) ||
                          (src == int'(PC_BRANCH_TARGET));
                if (stall_IF) begin
                    nw = 1; ns = src;
                end else if (misaligned_fetch && is_jump) begin
                    e_ki = 1; nw = 0; ne = 1;
                end else begin
                    e_ki = 1;
                    e_kd = (src == int'(PC_HANDLER)) || (src == int'(PC_EPC));
                    nc = m_cnt + 1; nw = 0;
                end
            end
        end
        nc = nc % (1 << CW);

        chk("sel", 32'(PC_src_sel), 32'(e_sel));
        chk("kill_IF", 32'(kill_IF), 32'(e_ki));
        chk("kill_DX", 32'(kill_DX), 32'(e_kd));
        chk("misaligned_exc", 32'(misaligned_exc), 32'(e_exc));
        chk("redirect_pending", 32'(redirect_pending), 32'(e_pend));
        chk("redirect_count", 32'(redirect_count), 32'(m_cnt));

        m_wait = nw; m_exc = ne; m_src = ns; m_cnt = nc;
    endtask

    // Inputs change on the falling edge; outputs are compared 1 ns later,
    // well before the next rising edge.
    task automatic step(input bit r, input bit st, input bit tr, input bit er,
                        input bit jr, input bit j, input bit b, input bit mis);
        @(negedge clk);
        reset = r; stall_IF = st; trap_req = tr; eret_req = er;
        jalr_DX = jr; jal_DX = j; branch_taken_DX = b; misaligned_fetch = mis;
        #1;
        model_cycle();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 0);
        chk("lit_rst_sel", 32'(PC_src_sel), 32'd5);
        chk("lit_rst_kill", {30'd0, kill_IF, kill_DX}, 32'd3);
        idle();
        chk("lit_rst_count", 32'(redirect_count), 32'd0);
        chk("lit_idle_sel", 32'(PC_src_sel), 32'd5);

        // Simple branch
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("lit_br_sel", 32'(PC_src_sel), 32'd1);
        chk("lit_br_kill", {30'd0, kill_IF, kill_DX}, 32'd2);
        idle();
        chk("lit_br_count", 32'(redirect_count), 32'd1);

        // JAL under a 3-cycle stall
        step(0, 1, 0, 0, 0, 1, 0, 0);
        chk("lit_jal_pend0", 32'(redirect_pending), 32'd0);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        chk("lit_jal_pend2", 32'(redirect_pending), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("lit_jal_sel", 32'(PC_src_sel), 32'd0);
        chk("lit_jal_rel", {30'd0, redirect_pending, kill_IF}, 32'd3);
        chk("lit_jal_cnt_hold", 32'(redirect_count), 32'd1);
        idle();
        chk("lit_jal_count", 32'(redirect_count), 32'd2);

        // Priority: trap beats eret and jalr
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("lit_prio_sel", 32'(PC_src_sel), 32'd3);
        chk("lit_prio_kill", {30'd0, kill_IF, kill_DX}, 32'd3);
        idle();
        chk("lit_prio_count", 32'(redirect_count), 32'd3);

        // Trap overrides a held JALR
        step(0, 1, 0, 0, 1, 0, 0, 0);
        chk("lit_ovr_sel0", 32'(PC_src_sel), 32'd6);
        step(0, 1, 1, 0, 1, 0, 0, 0);
        chk("lit_ovr_sel1", 32'(PC_src_sel), 32'd3);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_ovr_rel", {29'd0, PC_src_sel}, 32'd3);
        chk("lit_ovr_kd", 32'(kill_DX), 32'd1);
        idle();
        chk("lit_ovr_count", 32'(redirect_count), 32'd4);

        // Misaligned JAL
        step(0, 0, 0, 0, 0, 1, 0, 1);
        chk("lit_mis_exc0", 32'(misaligned_exc), 32'd0);
        idle();
        chk("lit_mis_exc1", 32'(misaligned_exc), 32'd1);
        chk("lit_mis_sel", 32'(PC_src_sel), 32'd3);
        idle();
        chk("lit_mis_exc2", 32'(misaligned_exc), 32'd0);
        chk("lit_mis_count", 32'(redirect_count), 32'd5);

        // Reset while holding
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0, 0);
        idle();
        chk("lit_rh_pend", 32'(redirect_pending), 32'd0);
        chk("lit_rh_count", 32'(redirect_count), 32'd0);

        // Counter wrap at 4 bits
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        chk("lit_wrap15", 32'(redirect_count), 32'd15);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        chk("lit_wrap0", 32'(redirect_count), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
